// File: rtl/change_dispenser_if.sv
// ----------------------------------------------------------------------------
// change_dispenser_if
// Handshake bundle between the vending controller, the change dispenser,
// the item actuator and the coin hopper.
//
// Parameters:
//   N : width of change amount and coin denomination (rupees)
//   D : width of the item code
//
// Signals:
//   in_valid / in_ready / in_item / in_change : vend or refund request
//   item_valid / item_ready / item_code       : item release handshake
//   coin_valid / coin_ready / coin_val        : coin release handshake
//   done                                      : transaction complete pulse
//   error                                     : sticky timeout flag
//
// Modports:
//   slave  : the dispenser's view
//   master : the surrounding environment's view
// ----------------------------------------------------------------------------
interface change_dispenser_if #(
    parameter int N = 7,
    parameter int D = 6
);
    logic         in_valid;
    logic         in_ready;
    logic [D-1:0] in_item;
    logic [N-1:0] in_change;
    logic         item_valid;
    logic [D-1:0] item_code;
    logic         item_ready;
    logic         coin_valid;
    logic [N-1:0] coin_val;
    logic         coin_ready;
    logic         done;
    logic         error;

    modport slave (
        input  in_valid, in_item, in_change, item_ready, coin_ready,
        output in_ready, item_valid, item_code, coin_valid, coin_val, done, error
    );

    modport master (
        output in_valid, in_item, in_change, item_ready, coin_ready,
        input  in_ready, item_valid, item_code, coin_valid, coin_val, done, error
    );
endinterface

// File: rtl/change_dispenser.sv
// ----------------------------------------------------------------------------
// change_dispenser
// Accepts one vend/refund request at a time, optionally releases an item,
// then pays the change out coin by coin using the greedy denomination set
// {50,20,10,5,2,1}, and finally pulses done.
//
// Parameters:
//   N   : width of change amount / coin denomination (must be >= 6)
//   D   : width of the item code
//   TMO : hopper/actuator wait limit in clk cycles (timeout build only)
//
// Ports:
//   clk  : system clock, rising edge
//   rstn : asynchronous active-low reset
//   bus  : change_dispenser_if.slave handshake bundle
//
// Build option:
//   HOPPER_TIMEOUT_EN : when defined, a wait counter bounds the ITEM and COIN
//                       handshakes; expiry enters a sticky ERR state that only
//                       rstn leaves. When undefined, waits are unbounded and
//                       error is tied low.
//
// All bus outputs come straight from registers. They are loaded from the
// decode of the next state, so they always agree with the state register.
// ----------------------------------------------------------------------------
module change_dispenser #(
    parameter int N   = 7,
    parameter int D   = 6,
    parameter int TMO = 16
) (
    input  logic              clk,
    input  logic              rstn,
    change_dispenser_if.slave bus
);

    // Configuration sanity: 50 must fit in N bits and the wait limit must be positive.
    if (N < 6 || TMO < 1) begin : g_bad_config
        $error("change_dispenser: N must be >= 6 and TMO must be >= 1");
    end

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ITEM   = 3'd1,
        S_SELECT = 3'd2,
        S_COIN   = 3'd3,
        S_DONE   = 3'd4
`ifdef HOPPER_TIMEOUT_EN
        ,S_ERR   = 3'd5
`endif
    } state_e;

    // Largest greedy denomination not exceeding the remaining amount.
    // Widened to 32 bits so the thresholds compare cleanly for any N.
    function automatic logic [N-1:0] greedy_denom(input logic [N-1:0] rem);
        logic [31:0] r;
        r = 32'(rem);
        if (r >= 32'd50) begin
            greedy_denom = N'(32'd50);
        end else if (r >= 32'd20) begin
            greedy_denom = N'(32'd20);
        end else if (r >= 32'd10) begin
            greedy_denom = N'(32'd10);
        end else if (r >= 32'd5) begin
            greedy_denom = N'(32'd5);
        end else if (r >= 32'd2) begin
            greedy_denom = N'(32'd2);
        end else if (r >= 32'd1) begin
            greedy_denom = N'(32'd1);
        end else begin
            greedy_denom = {N{1'b0}};
        end
    endfunction

    // N-bit subtraction that clamps at zero instead of wrapping.
    function automatic logic [N-1:0] sub_clamp(input logic [N-1:0] a, input logic [N-1:0] b);
        if (a >= b) begin
            sub_clamp = a - b;
        end else begin
            sub_clamp = {N{1'b0}};
        end
    endfunction

    state_e       state_r;
    state_e       state_s;
    logic [D-1:0] item_r;
    logic [D-1:0] item_s;
    logic [N-1:0] remaining_r;
    logic [N-1:0] remaining_s;
    logic [N-1:0] denom_s;

    logic         in_ready_r;
    logic         item_valid_r;
    logic [D-1:0] item_code_r;
    logic         coin_valid_r;
    logic [N-1:0] coin_val_r;
    logic         done_r;

    logic         in_ready_s;
    logic         item_valid_s;
    logic [D-1:0] item_code_s;
    logic         coin_valid_s;
    logic [N-1:0] coin_val_s;
    logic         done_s;

    logic         accept_s;
    logic         item_hs_s;
    logic         coin_hs_s;

    // Handshakes qualify on our own registered valids, so a ready without a
    // matching valid (or a request outside IDLE) has no effect.
    always_comb begin
        accept_s  = in_ready_r   & bus.in_valid;
        item_hs_s = item_valid_r & bus.item_ready;
        coin_hs_s = coin_valid_r & bus.coin_ready;
    end

`ifdef HOPPER_TIMEOUT_EN
    localparam int CW = $clog2(TMO + 1);

    logic [CW-1:0] tmo_cnt_r;
    logic          wait_s;
    logic          tmo_hit_s;
    logic          error_r;
    logic          error_s;

    // A wait cycle is any ITEM/COIN cycle whose handshake does not complete.
    // The limit fires on the wait cycle that would bring the count to TMO.
    always_comb begin
        wait_s    = ((state_r == S_ITEM) && !item_hs_s) ||
                    ((state_r == S_COIN) && !coin_hs_s);
        tmo_hit_s = wait_s && (tmo_cnt_r == CW'(TMO - 1));
    end

    // Wait counter: cleared when a handshake state is entered, counts waits.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tmo_cnt_r <= {CW{1'b0}};
        end else if ((state_s != state_r) && ((state_s == S_ITEM) || (state_s == S_COIN))) begin
            tmo_cnt_r <= {CW{1'b0}};
        end else if (wait_s) begin
            tmo_cnt_r <= tmo_cnt_r + CW'(1);
        end else begin
            tmo_cnt_r <= tmo_cnt_r;
        end
    end
`endif

    // Next-state, datapath updates and next-output decode.
    always_comb begin
        state_s     = state_r;
        item_s      = item_r;
        remaining_s = remaining_r;
        denom_s     = coin_val_r;

        case (state_r)
            S_IDLE: begin
                if (accept_s) begin
                    item_s      = bus.in_item;
                    remaining_s = bus.in_change;
                    if (bus.in_item != {D{1'b0}}) begin
                        state_s = S_ITEM;
                    end else begin
                        state_s = S_SELECT;
                    end
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_ITEM: begin
                if (item_hs_s) begin
                    state_s = S_SELECT;
                end
`ifdef HOPPER_TIMEOUT_EN
                else if (tmo_hit_s) begin
                    state_s = S_ERR;
                end
`endif
                else begin
                    state_s = S_ITEM;
                end
            end
            S_SELECT: begin
                if (remaining_r == {N{1'b0}}) begin
                    state_s = S_DONE;
                end else begin
                    denom_s = greedy_denom(remaining_r);
                    state_s = S_COIN;
                end
            end
            S_COIN: begin
                if (coin_hs_s) begin
                    remaining_s = sub_clamp(remaining_r, coin_val_r);
                    state_s     = S_SELECT;
                end
`ifdef HOPPER_TIMEOUT_EN
                else if (tmo_hit_s) begin
                    state_s = S_ERR;
                end
`endif
                else begin
                    state_s = S_COIN;
                end
            end
            S_DONE: begin
                state_s = S_IDLE;
            end
`ifdef HOPPER_TIMEOUT_EN
            S_ERR: begin
                state_s = S_ERR;
            end
`endif
            default: begin
                state_s = S_IDLE;
            end
        endcase

        in_ready_s   = (state_s == S_IDLE);
        item_valid_s = (state_s == S_ITEM);
        item_code_s  = item_valid_s ? item_s : {D{1'b0}};
        coin_valid_s = (state_s == S_COIN);
        coin_val_s   = coin_valid_s ? denom_s : {N{1'b0}};
        done_s       = (state_s == S_DONE);
`ifdef HOPPER_TIMEOUT_EN
        error_s      = (state_s == S_ERR);
`endif
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r     <= S_IDLE;
            item_r      <= {D{1'b0}};
            remaining_r <= {N{1'b0}};
        end else begin
            state_r     <= state_s;
            item_r      <= item_s;
            remaining_r <= remaining_s;
        end
    end

    // Output registers; reset value is the IDLE output pattern.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            in_ready_r   <= 1'b1;
            item_valid_r <= 1'b0;
            item_code_r  <= {D{1'b0}};
            coin_valid_r <= 1'b0;
            coin_val_r   <= {N{1'b0}};
            done_r       <= 1'b0;
        end else begin
            in_ready_r   <= in_ready_s;
            item_valid_r <= item_valid_s;
            item_code_r  <= item_code_s;
            coin_valid_r <= coin_valid_s;
            coin_val_r   <= coin_val_s;
            done_r       <= done_s;
        end
    end

`ifdef HOPPER_TIMEOUT_EN
    // Sticky error flag register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            error_r <= 1'b0;
        end else begin
            error_r <= error_s;
        end
    end
    assign bus.error = error_r;
`else
    assign bus.error = 1'b0;
`endif

    assign bus.in_ready   = in_ready_r;
    assign bus.item_valid = item_valid_r;
    assign bus.item_code  = item_code_r;
    assign bus.coin_valid = coin_valid_r;
    assign bus.coin_val   = coin_val_r;
    assign bus.done       = done_r;

endmodule
